apo_node_injector: RTL and testbench

- Node-side network interface for one router of the circulant C(121; 7, 8) apo network.
- Accepts destination node numbers from the local compute node over a valid/ready handshake and buffers them in a small FIFO.
- Injects each destination onto the router's in_free port only in cycles when all four neighbour links into the router are idle. The router gives in_free absolute priority, so this gating keeps injection from displacing transit packets.
- Counts injected packets and local deliveries reported by the router's out_data pulse.

---
 rtl/apo_node_injector.sv | 114 +++++++++++
 tb/tb_apo_node_injector.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/apo_node_injector.sv
// Node-side injector for one router of the C(121; 7, 8) apo network: queues local
// destinations and feeds them to the router's in_free port only while all neighbour links are idle.
module apo_node_injector #(
  parameter int NODE_COUNT = 121,
  parameter int ADDR_W     = 7,
  parameter int PKT_W      = 15,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_LIM = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_dest,
  output logic              req_ready,
  output logic              req_err,
  input  logic [PKT_W-1:0]  link_r1R,
  input  logic [PKT_W-1:0]  link_r2R,
  input  logic [PKT_W-1:0]  link_r1L,
  input  logic [PKT_W-1:0]  link_r2L,
  output logic [PKT_W-1:0]  out_free,
  input  logic              dlv_in,
  output logic [15:0]       tx_count,
  output logic [15:0]       rx_count,
  output logic [2:0]        fifo_level,
  output logic              starve
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W:0]    DEST_LIM  = (ADDR_W + 1)'(NODE_COUNT);
  localparam logic [CNT_W-1:0]   FULL_LVL  = CNT_W'(FIFO_DEPTH);
  localparam logic [7:0]         STARVE_TH = 8'(STARVE_LIM);

  logic [ADDR_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  level_q, level_d;
  logic [15:0]       tx_q, rx_q;
  logic [7:0]        wait_q, wait_d;
  logic              err_q;

  logic full, empty, accept, legal, push, busy, inject;
  logic [ADDR_W-1:0] head;
  logic              unused_link_bits;

  assign full   = (level_q == FULL_LVL);
  assign empty  = (level_q == '0);
  assign accept = req_valid && !full;
  assign legal  = ({1'b0, req_dest} < DEST_LIM);
  assign push   = accept && legal;
  assign busy   = link_r1R[PKT_W-1] | link_r2R[PKT_W-1] | link_r1L[PKT_W-1] | link_r2L[PKT_W-1];
  assign inject = !empty && !busy;
  assign head   = mem_q[rd_ptr_q];

  // Only the valid flags of the snooped links matter for the idle test.
  assign unused_link_bits = ^{link_r1R[PKT_W-2:0], link_r2R[PKT_W-2:0],
                              link_r1L[PKT_W-2:0], link_r2L[PKT_W-2:0]};

  // Router samples in_free and its links on the same edge, so this must stay combinational.
  assign out_free = inject ? {1'b1, {(PKT_W-1-ADDR_W){1'b0}}, head} : '0;

  always_comb begin
    level_d = level_q;
    case ({push, inject})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if (empty || inject)
      wait_d = '0;
    else if (wait_q != 8'hFF)
      wait_d = wait_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= req_dest;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      wait_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (inject) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        tx_q     <= tx_q + 16'd1;
      end
      if (dlv_in)
        rx_q <= rx_q + 16'd1;
      level_q <= level_d;
      wait_q  <= wait_d;
      err_q   <= accept && !legal;
    end
  end

  assign req_ready  = !full;
  assign req_err    = err_q;
  assign tx_count   = tx_q;
  assign rx_count   = rx_q;
  assign fifo_level = 3'(level_q);
  assign starve     = (wait_q >= STARVE_TH);

endmodule

// File: tb/tb_apo_node_injector.sv
// Directed bench for apo_node_injector: hand-computed expectations for enqueue, gated
// injection, over-range rejection, starvation, delivery counting and async reset.
module tb_apo_node_injector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [6:0]  req_dest;
  logic        req_ready;
  logic        req_err;
  logic [14:0] link_r1R, link_r2R, link_r1L, link_r2L;
  logic [14:0] out_free;
  logic        dlv_in;
  logic [15:0] tx_count, rx_count;
  logic [2:0]  fifo_level;
  logic        starve;

  int n_checks = 0;
  int n_errors = 0;

  apo_node_injector dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_dest(req_dest), .req_ready(req_ready), .req_err(req_err),
    .link_r1R(link_r1R), .link_r2R(link_r2R), .link_r1L(link_r1L), .link_r2L(link_r2L),
    .out_free(out_free), .dlv_in(dlv_in),
    .tx_count(tx_count), .rx_count(rx_count), .fifo_level(fifo_level), .starve(starve)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_dest = '0; dlv_in = 1'b0;
    link_r1R = '0; link_r2R = '0; link_r1L = '0; link_r2L = '0;
    #3;
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_out", 32'(out_free), 32'd0);
    check("rst_tx", 32'(tx_count), 32'd0);
    check("rst_rx", 32'(rx_count), 32'd0);
    check("rst_err", 32'(req_err), 32'd0);
    check("rst_starve", 32'(starve), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    step();
    rst_n = 1'b1;
    step();

    // single destination, idle links
    req_valid = 1'b1; req_dest = 7'd5;
    step();
    req_valid = 1'b0;
    check("t1_level", 32'(fifo_level), 32'd1);
    check("t1_out", 32'(out_free), 32'h4005);
    check("t1_tx_pre", 32'(tx_count), 32'd0);
    step();
    check("t1_tx", 32'(tx_count), 32'd1);
    check("t1_level0", 32'(fifo_level), 32'd0);
    check("t1_out0", 32'(out_free), 32'd0);

    // fill while link_r1R busy, then drain in order
    link_r1R = 15'h4081;
    req_valid = 1'b1;
    req_dest = 7'd3;   step();
    req_dest = 7'd9;   step();
    req_dest = 7'd17;  step();
    req_dest = 7'd120; step();
    req_valid = 1'b0;
    check("t2_level4", 32'(fifo_level), 32'd4);
    check("t2_ready0", 32'(req_ready), 32'd0);
    check("t2_out_busy", 32'(out_free), 32'd0);
    step();
    check("t2_hold_level", 32'(fifo_level), 32'd4);
    check("t2_hold_tx", 32'(tx_count), 32'd1);
    link_r1R = '0;
    #1;
    check("t2_inj3", 32'(out_free), 32'h4003);
    step();
    check("t2_inj9", 32'(out_free), 32'h4009);
    check("t2_ready1", 32'(req_ready), 32'd1);
    step();
    check("t2_inj17", 32'(out_free), 32'h4011);
    step();
    check("t2_inj120", 32'(out_free), 32'h4078);
    step();
    check("t2_tx", 32'(tx_count), 32'd5);
    check("t2_level0", 32'(fifo_level), 32'd0);
    check("t2_out0", 32'(out_free), 32'd0);

    // over-range destinations are rejected with a one-cycle error pulse
    check("t3_err_idle", 32'(req_err), 32'd0);
    req_valid = 1'b1; req_dest = 7'd121;
    step();
    check("t3_err121", 32'(req_err), 32'd1);
    check("t3_level121", 32'(fifo_level), 32'd0);
    req_dest = 7'd127;
    step();
    req_valid = 1'b0;
    check("t3_err127", 32'(req_err), 32'd1);
    check("t3_level127", 32'(fifo_level), 32'd0);
    check("t3_out", 32'(out_free), 32'd0);
    step();
    check("t3_err_end", 32'(req_err), 32'd0);
    check("t3_tx", 32'(tx_count), 32'd5);

    // starvation behind a busy link_r2L
    link_r2L = 15'h4001;
    req_valid = 1'b1; req_dest = 7'd42;
    step();
    req_valid = 1'b0;
    repeat (15) step();
    check("t4_starve15", 32'(starve), 32'd0);
    step();
    check("t4_starve16", 32'(starve), 32'd1);
    repeat (3) step();
    check("t4_out_busy", 32'(out_free), 32'd0);
    check("t4_starve_hold", 32'(starve), 32'd1);
    link_r2L = '0;
    #1;
    check("t4_inj", 32'(out_free), 32'h402A);
    step();
    check("t4_tx", 32'(tx_count), 32'd6);
    check("t4_starve_fall", 32'(starve), 32'd0);

    // deliveries counted independently of injection
    req_valid = 1'b1; req_dest = 7'd7; dlv_in = 1'b1;
    step();
    req_dest = 7'd8;
    step();
    check("t5_rx2", 32'(rx_count), 32'd2);
    check("t5_tx7", 32'(tx_count), 32'd7);
    check("t5_level1", 32'(fifo_level), 32'd1);
    req_dest = 7'd9;
    step();
    req_valid = 1'b0; dlv_in = 1'b0;
    check("t5_rx3", 32'(rx_count), 32'd3);
    check("t5_tx8", 32'(tx_count), 32'd8);
    step();
    check("t5_tx9", 32'(tx_count), 32'd9);
    check("t5_rx_hold", 32'(rx_count), 32'd3);

    // asynchronous reset with three queued entries
    link_r1L = 15'h4010;
    req_valid = 1'b1;
    req_dest = 7'd10; step();
    req_dest = 7'd11; step();
    req_dest = 7'd12; step();
    req_valid = 1'b0;
    check("t6_level3", 32'(fifo_level), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_level_rst", 32'(fifo_level), 32'd0);
    check("t6_tx_rst", 32'(tx_count), 32'd0);
    check("t6_rx_rst", 32'(rx_count), 32'd0);
    check("t6_out_rst", 32'(out_free), 32'd0);
    step();
    rst_n = 1'b1;
    link_r1L = '0;
    #1;
    check("t6_out_after", 32'(out_free), 32'd0);
    repeat (3) step();
    check("t6_tx_after", 32'(tx_count), 32'd0);
    check("t6_level_after", 32'(fifo_level), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
